rr_select_arbiter_2x1: RTL
==========================

Name: rr_select_arbiter_2x1

Overview:
- Two-channel round-robin arbiter with a registered output slot.
- Sits directly upstream of the gate-level 2:1 mux in Basic_Blocks and generates its select bit S.
- Merges two valid/ready request streams into one output stream. S reports which channel owns the data currently held in the output register.
- Also keeps per-channel transfer counters for debug and bench checking.

Parameters:
- WIDTH, 8, payload width of each channel and of the output.
- CNTW, 8, width of each per-channel transfer counter.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- V0  input  1  channel 0 request valid.
- I0  input  WIDTH  channel 0 payload.
- R0  output  1  channel 0 ready (grant); combinational.
- V1  input  1  channel 1 request valid.
- I1  input  WIDTH  channel 1 payload.
- R1  output  1  channel 1 ready (grant); combinational.
- F  output  WIDTH  registered output payload.
- FV  output  1  output valid.
- FR  input  1  downstream ready.
- S  output  1  registered select: 0 = F came from channel 0, 1 = from channel 1.
- CNT0  output  CNTW  accepted-transfer count, channel 0.
- CNT1  output  CNTW  accepted-transfer count, channel 1.

Behaviour:
- Reset, asynchronous on RST high, values held while RST is high:
  - FV=0, F=0, S=0.
  - Priority pointer PRI=0 (channel 0 wins the first tie).
  - CNT0=0, CNT1=0.
  - R0 and R1 are forced to 0 while RST is high.
- Load enable:
  - LD = !FV | FR (output slot empty, or being drained this cycle).
  - Allows full throughput of one transfer per cycle.
- Grant, combinational:
  - If LD=0: R0=R1=0.
  - Else if V0 & V1: grant channel PRI.
  - Else: grant whichever channel is valid.
  - At most one of R0/R1 is high. A ready is never asserted without the matching valid.
- Transfer on a channel occurs when Vx & Rx at the rising edge. On that edge:
  - F <= Ix.
  - S <= x.
  - FV <= 1.
  - PRI <= ~x: the granted channel loses priority, whether or not the other channel was requesting.
  - CNTx <= CNTx + 1, wrapping modulo 2^CNTW (0xFF -> 0x00 at default).
- Drain:
  - If FV & FR and no new transfer: FV <= 0.
  - F and S hold their last values; they are don't-care to consumers while FV=0.
- Stall:
  - FV=1 & FR=0 means F, S and FV hold.
  - No grant, PRI unchanged, counters unchanged.
- Latency: one cycle from accepted request to FV=1.
- Simultaneous drain and load: output stays valid with new data. FV remains 1 with no bubble.
- Fairness:
  - With both channels continuously valid and FR=1, grants alternate 0,1,0,1...
  - Neither channel waits more than one transfer slot.
- Inputs are sampled only on transfer. Upstream may change Ix while Vx=0.
- RST asserted mid-transfer aborts the transfer: the output slot is discarded and nothing is counted.
- After RST deasserts, the first transfer occurs no earlier than the first rising edge at which RST is low.

Test Plan:
- Reset check: hold RST=1 for 3 cycles with V0=V1=1 -> R0=R1=0, FV=0, F=0, S=0, CNT0=CNT1=0 throughout.
- Single channel: V1=1, I1=0x5A, FR=1, V0=0 -> R1=1 same cycle; next cycle FV=1, F=0x5A, S=1, CNT1=1; PRI now 0.
- Round-robin: V0=V1=1 continuously, I0=0x11, I1=0x22, FR=1 for 6 cycles:
  - F sequence 0x11,0x22,0x11,0x22,0x11,0x22 with S 0,1,0,1,0,1.
  - CNT0=CNT1=3.
- Backpressure: FV=1 with F=0x11, FR=0 for 4 cycles, V0=V1=1 -> R0=R1=0; F, S and CNTs frozen. FR=1 -> the next grant goes to channel 1.
- Counter wrap: 256 channel-0 transfers -> CNT0 returns to 0x00, CNT1 unchanged.
- Async reset mid-stream: assert RST between clock edges while FV=1 -> FV, F, S and CNTs go to 0 immediately without waiting for an edge. After release, a tie is granted to channel 0.

Source files
------------

// File: rtl/rr_select_arbiter_2x1.sv
// Two-channel round-robin arbiter with a registered output slot.
// Merges two valid/ready streams into one. S tells the downstream 2:1 mux
// which channel owns the payload currently held in F. Per-channel transfer
// counters are kept for debug visibility.
module rr_select_arbiter_2x1 #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             V0,
    input  logic [WIDTH-1:0] I0,
    output logic             R0,
    input  logic             V1,
    input  logic [WIDTH-1:0] I1,
    output logic             R1,
    output logic [WIDTH-1:0] F,
    output logic             FV,
    input  logic             FR,
    output logic             S,
    output logic [CNTW-1:0]  CNT0,
    output logic [CNTW-1:0]  CNT1
);

    logic             fv_r;
    logic [WIDTH-1:0] f_r;
    logic             s_r;
    logic             pri_r;
    logic [CNTW-1:0]  cnt0_r;
    logic [CNTW-1:0]  cnt1_r;

    logic             ld_s;
    logic             grant0_s;
    logic             grant1_s;

    // The slot can take new data when it is empty or being drained this cycle.
    assign ld_s = (~fv_r) | FR;

    // Grant selection: priority pointer breaks ties, lone requester always wins.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (RST) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (!ld_s) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (V0 && V1) begin
            if (pri_r) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b1;
            end
        end else if (V0) begin
            grant0_s = 1'b1;
        end else if (V1) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Output slot, priority pointer and transfer counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fv_r   <= 1'b0;
            f_r    <= {WIDTH{1'b0}};
            s_r    <= 1'b0;
            pri_r  <= 1'b0;
            cnt0_r <= {CNTW{1'b0}};
            cnt1_r <= {CNTW{1'b0}};
        end else if (grant0_s) begin
            fv_r   <= 1'b1;
            f_r    <= I0;
            s_r    <= 1'b0;
            pri_r  <= 1'b1;
            cnt0_r <= cnt0_r + CNTW'(1);
        end else if (grant1_s) begin
            fv_r   <= 1'b1;
            f_r    <= I1;
            s_r    <= 1'b1;
            pri_r  <= 1'b0;
            cnt1_r <= cnt1_r + CNTW'(1);
        end else if (fv_r && FR) begin
            // Drained with nothing to replace it; F and S keep their last values.
            fv_r   <= 1'b0;
        end else begin
            fv_r   <= fv_r;
        end
    end

    assign R0   = grant0_s;
    assign R1   = grant1_s;
    assign F    = f_r;
    assign FV   = fv_r;
    assign S    = s_r;
    assign CNT0 = cnt0_r;
    assign CNT1 = cnt1_r;

endmodule
